// File: rtl/scan_index_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scan_index_gen_if : control/status bundle of the LED scan indexer  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface scan_index_gen_if;
   logic       run;
   logic [1:0] mode;
   logic       step_key_n;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] idx;
   logic       dir;
   logic       tick;
   logic       wrap;

   modport master (
      output run, mode, step_key_n, load, load_val,
      input  idx, dir, tick, wrap
   );

   modport slave (
      input  run, mode, step_key_n, load, load_val,
      output idx, dir, tick, wrap
   );
endinterface
`default_nettype wire

// File: rtl/scan_index_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scan_index_gen : 4-bit LED scan index, auto-rate or debounced key  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module scan_index_gen #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TICK_HZ    = 8,
   parameter int DEB_CYCLES = 1_000_000
) (
   input wire logic         CLOCK_50,
   input wire logic         rst_n,
   scan_index_gen_if.slave  bus
);

   localparam int c_div   = CLK_HZ / TICK_HZ;
   localparam int c_pre_w = $clog2(c_div);
   localparam int c_deb_w = $clog2(DEB_CYCLES);

   localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(c_div - 1);
   localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);
   localparam logic [c_deb_w-1:0] c_deb_one  = c_deb_w'(1);

   localparam logic [1:0] c_mode_up     = 2'b00;
   localparam logic [1:0] c_mode_down   = 2'b01;
   localparam logic [1:0] c_mode_bounce = 2'b10;
   localparam logic [1:0] c_mode_hold   = 2'b11;

   typedef enum logic [1:0] {
      ST_HI_STABLE = 2'd0,
      ST_HI_TO_LO  = 2'd1,
      ST_LO_STABLE = 2'd2,
      ST_LO_TO_HI  = 2'd3
   } deb_state_t;

   logic               key_meta_q;
   logic               key_sync_q;
   deb_state_t         deb_state_q;
   logic [c_deb_w-1:0] deb_cnt_q;
   logic               key_deb_q;
   logic               step_pulse_q;
   logic [c_pre_w-1:0] pre_q;
   logic [3:0]         idx_q;
   logic [3:0]         idx_d;
   logic               dir_q;
   logic               dir_d;
   logic               tick_q;
   logic               tick_d;
   logic               wrap_q;
   logic               wrap_d;
   logic               w_tick_int;
   logic               w_adv;

   // Raw key is asynchronous to CLOCK_50; idle level is high.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         key_meta_q <= 1'b1;
         key_sync_q <= 1'b1;
      end else begin
         key_meta_q <= bus.step_key_n;
         key_sync_q <= key_meta_q;
      end
   end

   // Transitional states count consecutive disagreeing samples; the
   // DEB_CYCLES-th one commits. Only the press (commit to low) steps.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         deb_state_q  <= ST_HI_STABLE;
         deb_cnt_q    <= '0;
         key_deb_q    <= 1'b1;
         step_pulse_q <= 1'b0;
      end else begin
         step_pulse_q <= 1'b0;
         unique case (deb_state_q)
            ST_HI_STABLE: begin
               if (!key_sync_q) begin
                  deb_state_q <= ST_HI_TO_LO;
                  deb_cnt_q   <= c_deb_one;
               end
            end
            ST_HI_TO_LO: begin
               if (key_sync_q) begin
                  deb_state_q <= ST_HI_STABLE;
                  deb_cnt_q   <= '0;
               end else if (deb_cnt_q == c_deb_last) begin
                  deb_state_q  <= ST_LO_STABLE;
                  deb_cnt_q    <= '0;
                  key_deb_q    <= 1'b0;
                  step_pulse_q <= 1'b1;
               end else begin
                  deb_cnt_q <= deb_cnt_q + c_deb_one;
               end
            end
            ST_LO_STABLE: begin
               if (key_sync_q) begin
                  deb_state_q <= ST_LO_TO_HI;
                  deb_cnt_q   <= c_deb_one;
               end
            end
            ST_LO_TO_HI: begin
               if (!key_sync_q) begin
                  deb_state_q <= ST_LO_STABLE;
                  deb_cnt_q   <= '0;
               end else if (deb_cnt_q == c_deb_last) begin
                  deb_state_q <= ST_HI_STABLE;
                  deb_cnt_q   <= '0;
                  key_deb_q   <= 1'b1;
               end else begin
                  deb_cnt_q <= deb_cnt_q + c_deb_one;
               end
            end
         endcase
      end
   end

   assign w_tick_int = bus.run && (pre_q == c_pre_last);
   assign w_adv      = bus.run ? w_tick_int : (step_pulse_q && key_deb_q == 1'b0);

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else if (!bus.run || bus.load || w_tick_int) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + c_pre_w'(1);
      end
   end

   always_comb begin
      idx_d  = idx_q;
      dir_d  = dir_q;
      tick_d = 1'b0;
      wrap_d = 1'b0;
      if (bus.load) begin
         idx_d = bus.load_val;
      end else if (w_adv) begin
         tick_d = 1'b1;
         unique case (bus.mode)
            c_mode_up: begin
               dir_d  = 1'b0;
               idx_d  = idx_q + 4'd1;
               wrap_d = (idx_q == 4'd15);
            end
            c_mode_down: begin
               dir_d  = 1'b1;
               idx_d  = idx_q - 4'd1;
               wrap_d = (idx_q == 4'd0);
            end
            c_mode_bounce: begin
               // Reversal is taken at the end value itself, so the end
               // value is shown once per sweep.
               if (!dir_q) begin
                  if (idx_q == 4'd15) begin
                     idx_d  = 4'd14;
                     dir_d  = 1'b1;
                     wrap_d = 1'b1;
                  end else begin
                     idx_d = idx_q + 4'd1;
                  end
               end else begin
                  if (idx_q == 4'd0) begin
                     idx_d  = 4'd1;
                     dir_d  = 1'b0;
                     wrap_d = 1'b1;
                  end else begin
                     idx_d = idx_q - 4'd1;
                  end
               end
            end
            c_mode_hold: begin
               idx_d = idx_q;
            end
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= 4'd0;
         dir_q  <= 1'b0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         dir_q  <= dir_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.idx  = idx_q;
   assign bus.dir  = dir_q;
   assign bus.tick = tick_q;
   assign bus.wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_index_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_scan_index_gen : scoreboard bench for scan_index_gen            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_scan_index_gen;
   localparam int CLK_HZ  = 8;
   localparam int TICK_HZ = 2;
   localparam int DEB     = 4;
   localparam int DIV     = CLK_HZ / TICK_HZ;

   typedef struct {
      int         cyc;
      logic [3:0] idx;
      logic       dir;
      logic       tick;
      logic       wrap;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic done  = 1'b0;
   int   cyc   = 0;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];
   exp_t mon_e;
   logic [3:0] prev_idx = 4'd0;
   logic       prev_dir = 1'b0;
   string      rst_tag  = "init";

   int m_idx = 0;
   int m_dir = 0;
   int m_pre = 0;

   scan_index_gen_if bus ();

   scan_index_gen #(
      .CLK_HZ     (CLK_HZ),
      .TICK_HZ    (TICK_HZ),
      .DEB_CYCLES (DEB)
   ) dut (
      .CLOCK_50 (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: one advance applied at edge 'at' under mode 'md'.
   task automatic model_advance(input int at, input logic [1:0] md);
      exp_t e;
      int   w;
      w = 0;
      case (md)
         2'b00: begin w = (m_idx == 15); m_idx = (m_idx + 1) % 16; m_dir = 0; end
         2'b01: begin w = (m_idx == 0); m_idx = (m_idx + 15) % 16; m_dir = 1; end
         2'b10: begin
            if (m_dir == 0) begin
               if (m_idx == 15) begin m_idx = 14; m_dir = 1; w = 1; end
               else m_idx = m_idx + 1;
            end else begin
               if (m_idx == 0) begin m_idx = 1; m_dir = 0; w = 1; end
               else m_idx = m_idx - 1;
            end
         end
         default: ;
      endcase
      e.cyc = at; e.idx = 4'(m_idx); e.dir = 1'(m_dir); e.tick = 1'b1; e.wrap = 1'(w);
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic r, input logic [1:0] md, input logic key,
                        input logic ld, input logic [3:0] lv);
      exp_t e;
      @(negedge clk); #1;
      bus.run = r; bus.mode = md; bus.step_key_n = key; bus.load = ld; bus.load_val = lv;
      if (ld) begin
         m_pre = 0;
         if (int'(lv) != m_idx) begin
            e.cyc = cyc + 1; e.idx = lv; e.dir = 1'(m_dir); e.tick = 1'b0; e.wrap = 1'b0;
            sb_q.push_back(e);
         end
         m_idx = int'(lv);
      end else if (r) begin
         m_pre = m_pre + 1;
         if (m_pre == DIV) begin
            m_pre = 0;
            model_advance(cyc + 1, md);
         end
      end else begin
         m_pre = 0;
      end
   endtask

   // One debounced press with leading and trailing bounces shorter than DEB.
   task automatic press(input logic [1:0] md, input int nb);
      for (int b = 0; b < nb; b++) begin
         int lo = $urandom_range(1, DEB - 1);
         int hi = $urandom_range(1, 3);
         repeat (lo) drive(1'b0, md, 1'b0, 1'b0, 4'd0);
         repeat (hi) drive(1'b0, md, 1'b1, 1'b0, 4'd0);
      end
      drive(1'b0, md, 1'b0, 1'b0, 4'd0);
      model_advance(cyc + 1 + DEB + 2, md);
      repeat (DEB + 5) drive(1'b0, md, 1'b0, 1'b0, 4'd0);
      for (int b = 0; b < nb; b++) begin
         int hi = $urandom_range(1, DEB - 1);
         int lo = $urandom_range(1, 3);
         repeat (hi) drive(1'b0, md, 1'b1, 1'b0, 4'd0);
         repeat (lo) drive(1'b0, md, 1'b0, 1'b0, 4'd0);
      end
      repeat (DEB + 6) drive(1'b0, md, 1'b1, 1'b0, 4'd0);
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk); #1;
      rst_tag = tag;
      rst_n = 1'b0;
      bus.run = 1'b0; bus.load = 1'b0; bus.step_key_n = 1'b1;
      m_idx = 0; m_dir = 0; m_pre = 0;
      @(negedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Monitor: the only process that counts comparisons.
   always begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
         #1;
         checks++;
         if ({bus.idx, bus.dir, bus.tick, bus.wrap} !== 7'd0) begin
            failures++;
            $display("FAIL reset_%s: got idx=%0d dir=%0d tick=%0d wrap=%0d, required all 0",
                     rst_tag, bus.idx, bus.dir, bus.tick, bus.wrap);
         end
      end else if (done) begin
         checks++;
         if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected events never seen, required 0", sb_q.size());
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end else begin
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_event: nothing seen at edge %0d, required idx=%0d dir=%0d tick=%0d wrap=%0d",
                     mon_e.cyc, mon_e.idx, mon_e.dir, mon_e.tick, mon_e.wrap);
         end
         if (bus.tick || bus.idx != prev_idx || bus.dir != prev_dir) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_event: edge %0d got idx=%0d dir=%0d tick=%0d wrap=%0d, required no change",
                        cyc, bus.idx, bus.dir, bus.tick, bus.wrap);
            end else begin
               mon_e = sb_q.pop_front();
               if (mon_e.cyc != cyc || mon_e.idx !== bus.idx || mon_e.dir !== bus.dir ||
                   mon_e.tick !== bus.tick || mon_e.wrap !== bus.wrap) begin
                  failures++;
                  $display("FAIL event: got edge=%0d idx=%0d dir=%0d tick=%0d wrap=%0d, required edge=%0d idx=%0d dir=%0d tick=%0d wrap=%0d",
                           cyc, bus.idx, bus.dir, bus.tick, bus.wrap,
                           mon_e.cyc, mon_e.idx, mon_e.dir, mon_e.tick, mon_e.wrap);
               end
            end
         end
      end
      prev_idx = bus.idx;
      prev_dir = bus.dir;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] rmode;
      bus.run = 1'b0; bus.mode = 2'b00; bus.step_key_n = 1'b1;
      bus.load = 1'b0; bus.load_val = 4'd0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      // Auto up-count across a wrap.
      repeat (70) drive(1'b1, 2'b00, 1'b1, 1'b0, 4'd0);

      // Bounce from idx 0 through both reversals.
      drive(1'b0, 2'b10, 1'b1, 1'b1, 4'd0);
      repeat (140) drive(1'b1, 2'b10, 1'b1, 1'b0, 4'd0);

      // Manual down step 0 -> 15 through 2-cycle-ish bounces, then random presses.
      drive(1'b0, 2'b01, 1'b1, 1'b1, 4'd0);
      press(2'b01, 2);
      repeat (5) press(2'($urandom_range(0, 3)), $urandom_range(0, 3));

      // Load coincident with an auto tick.
      drive(1'b0, 2'b00, 1'b1, 1'b1, 4'd3);
      for (int i = 0; i < 2 * DIV && m_pre != DIV - 1; i++)
         drive(1'b1, 2'b00, 1'b1, 1'b0, 4'd0);
      drive(1'b1, 2'b00, 1'b1, 1'b1, 4'd9);
      repeat (8) drive(1'b1, 2'b00, 1'b1, 1'b0, 4'd0);

      // Hold mode keeps ticking without moving.
      repeat (20) drive(1'b1, 2'b11, 1'b1, 1'b0, 4'd0);

      // Reset mid-prescale, then full DIV latency afterwards.
      drive(1'b1, 2'b00, 1'b1, 1'b1, 4'd5);
      repeat (2) drive(1'b1, 2'b00, 1'b1, 1'b0, 4'd0);
      pulse_reset("mid_prescale");
      repeat (10) drive(1'b1, 2'b00, 1'b1, 1'b0, 4'd0);

      // Reset mid-debounce; key then stays high, so no step may follow.
      drive(1'b0, 2'b00, 1'b1, 1'b1, 4'd7);
      repeat (DEB + 1) drive(1'b0, 2'b00, 1'b0, 1'b0, 4'd0);
      pulse_reset("mid_debounce");
      repeat (DEB + 8) drive(1'b0, 2'b00, 1'b1, 1'b0, 4'd0);

      // Randomized auto operation with loads and mode changes.
      rmode = 2'b00;
      repeat (300) begin
         if ($urandom_range(0, 29) == 0) rmode = 2'($urandom_range(0, 3));
         drive(1'($urandom_range(0, 9) != 0), rmode, 1'b1,
               1'($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)));
      end

      repeat (3) drive(1'b0, 2'b00, 1'b1, 1'b0, 4'd0);
      @(negedge clk); #1;
      done = 1'b1;
   end
endmodule
`default_nettype wire
